// File: rtl/spi_shader_loader.sv
// SPI master (CPOL=0, CPHA=1, MSB first) that streams command/data bytes to the shader.
// CS stays low across a burst; a byte flagged last closes CS and inserts a CS-high gap.
module spi_shader_loader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_mode_i,
  input  logic       tx_last_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_cs_o,
  output logic       mode_o
);

  localparam int unsigned   CW      = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam bit            DIV1    = (CLK_DIV == 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, WAIT, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d, bit_dec;
  logic [7:0]      data_q, data_d;
  logic            last_q, last_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            pend_q, pend_d;
  logic            tx_ready_d, rx_valid_d, busy_d, sclk_d, mosi_d, cs_d, mode_d;
  logic [7:0]      rx_data_d;
  logic            accept;

  assign accept = tx_valid_i && tx_ready_o;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      rx_sh_q    <= '0;
      pend_q     <= 1'b0;
      tx_ready_o <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      spi_sclk_o <= 1'b0;
      spi_mosi_o <= 1'b0;
      spi_cs_o   <= 1'b1;
      mode_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      last_q     <= last_d;
      rx_sh_q    <= rx_sh_d;
      pend_q     <= pend_d;
      tx_ready_o <= tx_ready_d;
      rx_data_o  <= rx_data_d;
      rx_valid_o <= rx_valid_d;
      busy_o     <= busy_d;
      spi_sclk_o <= sclk_d;
      spi_mosi_o <= mosi_d;
      spi_cs_o   <= cs_d;
      mode_o     <= mode_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    bit_dec    = bit_q - 3'd1;
    data_d     = data_q;
    last_d     = last_q;
    rx_sh_d    = rx_sh_q;
    pend_d     = pend_q;
    rx_data_d  = rx_data_o;
    rx_valid_d = 1'b0;
    sclk_d     = spi_sclk_o;
    mosi_d     = spi_mosi_o;
    cs_d       = spi_cs_o;
    mode_d     = mode_o;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = tx_data_i;
          last_d  = tx_last_i;
          mode_d  = tx_mode_i;
          bit_d   = bit_dec;
          cs_d    = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          mosi_d  = data_q[bit_q];
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
          if (DIV1 && bit_q == 3'd0 && !last_q) begin
            pend_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOW: begin
        // Final LOW cycle of a non-last byte is spent in WAIT so the next byte can follow gaplessly
        if (!DIV1 && bit_q == 3'd0 && !last_q && cnt_q == CNT_PRE) begin
          cnt_d   = '0;
          pend_d  = 1'b1;
          state_d = WAIT;
        end else if (cnt_q == CNT_END) begin
          cnt_d = '0;
          if (bit_q == 3'd0) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_sh_q;
            state_d    = HOLD;
          end else begin
            bit_d   = bit_dec;
            sclk_d  = 1'b1;
            mosi_d  = data_q[bit_dec];
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
        end
        if (accept) begin
          data_d  = tx_data_i;
          last_d  = tx_last_i;
          mode_d  = tx_mode_i;
          bit_d   = bit_dec;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          mosi_d  = tx_data_i[bit_dec];
          state_d = HIGH;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tx_ready_d = (state_d == IDLE) || (state_d == WAIT);
    busy_d     = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_shader_loader.sv
// Directed bench for spi_shader_loader: CLK_DIV=2 instance with MISO looped to MOSI,
// CLK_DIV=1 instance with MISO tied high.
module tb_spi_shader_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] tx_data, rx_data;
  logic       tx_mode, tx_last, tx_valid, tx_ready, rx_valid, busy, sclk, mosi, cs, mode;
  logic [7:0] tx_data1, rx_data1;
  logic       tx_mode1, tx_last1, tx_valid1, tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs1, mode1;

  spi_shader_loader #(.CLK_DIV(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .tx_data_i(tx_data), .tx_mode_i(tx_mode), .tx_last_i(tx_last), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(mosi), .spi_cs_o(cs), .mode_o(mode)
  );

  spi_shader_loader #(.CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .tx_data_i(tx_data1), .tx_mode_i(tx_mode1), .tx_last_i(tx_last1), .tx_valid_i(tx_valid1),
    .tx_ready_o(tx_ready1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1), .busy_o(busy1),
    .spi_sclk_o(sclk1), .spi_mosi_o(mosi1), .spi_miso_i(1'b1), .spi_cs_o(cs1), .mode_o(mode1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {logic [7:0] d; logic m; logic l;} ent_t;
  ent_t q[$];

  int          w_fall, w_cs_rise, w_rises, w_first_rise, w_mode_chg, w_mode_bad, w_rdy;
  int          rxc[$];
  logic [7:0]  rxb[$];
  logic [31:0] w_bits;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds queued bytes to the CLK_DIV=2 instance and records pin activity per cycle.
  task automatic watch(input int ncyc);
    logic psclk, pcs, pmode;
    bit   acc;
    w_fall = -1; w_cs_rise = -1; w_rises = 0; w_first_rise = -1;
    w_mode_chg = 0; w_mode_bad = 0; w_rdy = -1; w_bits = '0;
    rxc.delete(); rxb.delete();
    psclk = sclk; pcs = cs; pmode = mode;
    for (int c = 0; c < ncyc; c++) begin
      if (q.size() > 0) begin
        tx_valid = 1'b1; tx_data = q[0].d; tx_mode = q[0].m; tx_last = q[0].l;
      end else begin
        tx_valid = 1'b0;
      end
      if (pcs && !cs && w_fall < 0) w_fall = c;
      if (!pcs && cs && w_cs_rise < 0) w_cs_rise = c;
      if (!psclk && sclk) begin
        w_rises++;
        w_bits = {w_bits[30:0], mosi};
        if (w_first_rise < 0) w_first_rise = c;
      end
      if (mode !== pmode) begin
        w_mode_chg++;
        if (psclk !== 1'b0) w_mode_bad++;
      end
      if (rx_valid) begin rxc.push_back(c); rxb.push_back(rx_data); end
      if (w_cs_rise >= 0 && w_rdy < 0 && tx_ready) w_rdy = c;
      psclk = sclk; pcs = cs; pmode = mode;
      acc = tx_valid && tx_ready;
      step();
      if (acc) void'(q.pop_front());
    end
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if ({cs, sclk, mosi, mode} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_pins: got %b exp 1000", {cs, sclk, mosi, mode}); end
    n_cmp++; if ({rx_data, rx_valid, busy, tx_ready} !== 11'h000) begin
      n_bad++; $display("FAIL reset_status: got %h exp 000", {rx_data, rx_valid, busy, tx_ready}); end
    n_cmp++; if ({cs1, sclk1, busy1, tx_ready1} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_div1: got %b exp 1000", {cs1, sclk1, busy1, tx_ready1}); end
    rst = 1'b0;
    step();
    n_cmp++; if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: got %b exp 1", tx_ready); end
    n_cmp++; if (tx_ready1 !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset_div1: got %b exp 1", tx_ready1); end
  endtask

  task automatic test_single();
    int r0;
    logic [7:0] b0;
    q.push_back({8'hA5, 1'b0, 1'b1});
    watch(45);
    r0 = (rxc.size() > 0) ? rxc[0] : -1000;
    b0 = (rxb.size() > 0) ? rxb[0] : 8'hxx;
    n_cmp++; if (w_bits[7:0] !== 8'hA5 || w_rises != 8) begin
      n_bad++; $display("FAIL single_mosi: got %h/%0d rises exp a5/8", w_bits[7:0], w_rises); end
    n_cmp++; if (w_first_rise - w_fall != 2) begin
      n_bad++; $display("FAIL single_setup: got %0d exp 2", w_first_rise - w_fall); end
    n_cmp++; if (rxc.size() != 1 || r0 - w_fall != 34) begin
      n_bad++; $display("FAIL single_rx_time: got %0d strobes at %0d exp 1 at 34", rxc.size(), r0 - w_fall); end
    n_cmp++; if (b0 !== 8'hA5) begin
      n_bad++; $display("FAIL single_rx_data: got %h exp a5", b0); end
    n_cmp++; if (w_cs_rise - r0 != 2) begin
      n_bad++; $display("FAIL single_cs_rise: got %0d exp 2", w_cs_rise - r0); end
    n_cmp++; if (w_rdy - w_cs_rise != 2) begin
      n_bad++; $display("FAIL single_ready: got %0d exp 2", w_rdy - w_cs_rise); end
  endtask

  task automatic test_burst();
    q.push_back({8'h00, 1'b0, 1'b0});
    q.push_back({8'h3C, 1'b1, 1'b0});
    q.push_back({8'hFF, 1'b1, 1'b1});
    watch(110);
    n_cmp++; if (rxc.size() != 3) begin
      n_bad++; $display("FAIL burst_strobes: got %0d exp 3", rxc.size()); end
    else begin
      n_cmp++; if (rxc[0] - w_fall != 34 || rxc[1] - rxc[0] != 32 || rxc[2] - rxc[1] != 32) begin
        n_bad++; $display("FAIL burst_spacing: got %0d/%0d/%0d exp 34/32/32",
                          rxc[0] - w_fall, rxc[1] - rxc[0], rxc[2] - rxc[1]); end
      n_cmp++; if ({rxb[0], rxb[1], rxb[2]} !== 24'h003CFF) begin
        n_bad++; $display("FAIL burst_rx_data: got %h exp 003cff", {rxb[0], rxb[1], rxb[2]}); end
    end
    n_cmp++; if (w_rises != 24 || w_bits[23:0] !== 24'h003CFF) begin
      n_bad++; $display("FAIL burst_sclk: got %0d rises bits %h exp 24 003cff", w_rises, w_bits[23:0]); end
    n_cmp++; if (w_cs_rise - w_fall != 100) begin
      n_bad++; $display("FAIL burst_cs_low: got %0d exp 100", w_cs_rise - w_fall); end
    n_cmp++; if (w_mode_chg != 1 || w_mode_bad != 0 || mode !== 1'b1) begin
      n_bad++; $display("FAIL burst_mode: got chg=%0d bad=%0d mode=%b exp 1 0 1", w_mode_chg, w_mode_bad, mode); end
  endtask

  task automatic test_wait();
    int k;
    int viol;
    tx_data = 8'h5A; tx_mode = 1'b1; tx_last = 1'b0; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n_cmp++; if (cs !== 1'b0 || mode !== 1'b1) begin
      n_bad++; $display("FAIL wait_start: got cs=%b mode=%b exp 0 1", cs, mode); end
    k = 0;
    while (rx_valid !== 1'b1 && k < 40) begin step(); k++; end
    n_cmp++; if (k != 34 || rx_data !== 8'h5A) begin
      n_bad++; $display("FAIL wait_rx1: got %0d cycles data %h exp 34 5a", k, rx_data); end
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cs !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1 || mode !== 1'b1) viol++;
    end
    n_cmp++; if (viol != 0) begin
      n_bad++; $display("FAIL wait_hold: got %0d bad cycles exp 0", viol); end
    tx_data = 8'hC3; tx_mode = 1'b0; tx_last = 1'b1; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n_cmp++; if ({cs, sclk, mosi, mode} !== 4'b0110) begin
      n_bad++; $display("FAIL wait_no_setup: got %b exp 0110", {cs, sclk, mosi, mode}); end
    k = 0;
    while (rx_valid !== 1'b1 && k < 40) begin step(); k++; end
    n_cmp++; if (k != 32 || rx_data !== 8'hC3) begin
      n_bad++; $display("FAIL wait_rx2: got %0d cycles data %h exp 32 c3", k, rx_data); end
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset_mid();
    int nrx;
    int r0;
    logic [7:0] b0;
    tx_data = 8'h96; tx_mode = 1'b0; tx_last = 1'b1; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    n_cmp++; if (sclk !== 1'b1 || mosi !== 1'b1) begin
      n_bad++; $display("FAIL mid_bit4: got sclk=%b mosi=%b exp 1 1", sclk, mosi); end
    rst = 1'b1;
    step();
    n_cmp++; if ({cs, sclk, busy, rx_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL mid_abort: got %b exp 1000", {cs, sclk, busy, rx_valid}); end
    rst = 1'b0;
    nrx = 0;
    for (int i = 0; i < 40; i++) begin step(); if (rx_valid) nrx++; end
    n_cmp++; if (nrx != 0) begin
      n_bad++; $display("FAIL mid_no_rx: got %0d strobes exp 0", nrx); end
    q.push_back({8'h3C, 1'b1, 1'b1});
    watch(45);
    r0 = (rxc.size() > 0) ? rxc[0] : -1000;
    b0 = (rxb.size() > 0) ? rxb[0] : 8'hxx;
    n_cmp++; if (r0 - w_fall != 34 || b0 !== 8'h3C) begin
      n_bad++; $display("FAIL mid_recover: got %0d cycles data %h exp 34 3c", r0 - w_fall, b0); end
  endtask

  task automatic test_div1();
    int f = -1, r1 = -1, r2 = -1, rx1 = -1, nacc = 0, nr = 0;
    logic [7:0] bits = '0, rxd = '0;
    logic [2:0] rdy = '0;
    logic pcs, psc, cs_gap, acc;
    cs_gap = 1'b0;
    pcs = cs1; psc = sclk1;
    tx_data1 = 8'h81; tx_mode1 = 1'b1; tx_last1 = 1'b1; tx_valid1 = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (pcs && !cs1 && f < 0) f = c;
      if (!psc && sclk1) begin
        nr++;
        if (nr == 1) r1 = c;
        if (nr == 2) r2 = c;
        if (nr <= 8) bits = {bits[6:0], mosi1};
      end
      if (rx_valid1 && rx1 < 0) begin rx1 = c; rxd = rx_data1; end
      if (rx1 >= 0 && c - rx1 < 3) rdy = {rdy[1:0], tx_ready1};
      if (rx1 >= 0 && c == rx1 + 1) cs_gap = cs1;
      pcs = cs1; psc = sclk1;
      acc = tx_valid1 && tx_ready1;
      step();
      if (acc) begin nacc++; if (nacc == 2) tx_valid1 = 1'b0; end
    end
    tx_valid1 = 1'b0;
    n_cmp++; if (r1 - f != 1 || r2 - r1 != 2) begin
      n_bad++; $display("FAIL div1_sclk: got setup %0d period %0d exp 1 2", r1 - f, r2 - r1); end
    n_cmp++; if (bits !== 8'h81) begin
      n_bad++; $display("FAIL div1_mosi: got %h exp 81", bits); end
    n_cmp++; if (rx1 - f != 17 || rxd !== 8'hFF) begin
      n_bad++; $display("FAIL div1_rx: got %0d cycles data %h exp 17 ff", rx1 - f, rxd); end
    n_cmp++; if (rdy !== 3'b001 || cs_gap !== 1'b1) begin
      n_bad++; $display("FAIL div1_hold_gap: got ready %b cs %b exp 001 1", rdy, cs_gap); end
    n_cmp++; if (nacc != 2 || cs1 !== 1'b1 || busy1 !== 1'b0) begin
      n_bad++; $display("FAIL div1_second: got acc=%0d cs=%b busy=%b exp 2 1 0", nacc, cs1, busy1); end
  endtask

  initial begin
    rst = 1'b1;
    tx_data = '0; tx_mode = 1'b0; tx_last = 1'b0; tx_valid = 1'b0;
    tx_data1 = '0; tx_mode1 = 1'b0; tx_last1 = 1'b0; tx_valid1 = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_wait();
    test_reset_mid();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
